// File: rtl/mem_request_arbiter.sv
// Purpose : round-robin arbiter sharing one memory-controller request/return port among NUM_REQ requesters.
// Latency : accept in cycle N -> wr_en/rd_en in N+1; controller ack in cycle M -> done pulse in M+1.
// Backpr. : req_ready is held low while the table is full or the next candidate hits an outstanding address; done pulses have none.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_we      per-requester handshake and direction (1 = write)
//   req_address/req_data            16 bits per requester, requester i at [16i+15:16i]
//   wr_en/wr_address/wr_data        registered write request to the controller
//   rd_en/rd_address                registered read request to the controller
//   wr_ret_*/rd_ret_*               controller returns; the address is the return tag
//   wr_done/rd_done                 one-cycle completion pulse per requester
//   done_address/done_data          per-requester completion address and read data (0 for writes)
//   err_unmatched                   sticky flag: an ack matched no outstanding entry
module mem_request_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TABLE_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [16*NUM_REQ-1:0]  req_address,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [15:0]            wr_address,
  output logic [15:0]            wr_data,
  output logic                   wr_en,
  output logic [15:0]            rd_address,
  output logic                   rd_en,
  input  logic [15:0]            wr_ret_address,
  input  logic                   wr_ret_ack,
  input  logic [15:0]            rd_ret_address,
  input  logic [15:0]            rd_ret_data,
  input  logic                   rd_ret_ack,
  output logic [NUM_REQ-1:0]     wr_done,
  output logic [NUM_REQ-1:0]     rd_done,
  output logic [16*NUM_REQ-1:0]  done_address,
  output logic [16*NUM_REQ-1:0]  done_data,
  output logic                   err_unmatched
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [15:0]   addr;
    logic [OW-1:0] owner;
    logic          is_wr;
  } ent_t;

  ent_t                 tbl_q [TABLE_DEPTH];
  ent_t                 tbl_d [TABLE_DEPTH];
  logic [OW-1:0]        last_q, last_d;
  logic                 live_q;
  logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [15:0]          wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [15:0]          rd_addr_q, rd_addr_d;
  logic [NUM_REQ-1:0]   wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [16*NUM_REQ-1:0] done_addr_q, done_addr_d, done_data_q, done_data_d;
  logic                 err_q, err_d;

  logic                 cand_found, cand_we, tbl_full, hazard, grant;
  logic [OW-1:0]        cand;
  logic [15:0]          cand_addr, cand_data;
  logic                 alloc_done, wr_hit, rd_hit;
  logic [OW-1:0]        wr_owner, rd_owner;

  // Requester index k steps after base, wrapping at NUM_REQ.
  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return s[OW-1:0];
  endfunction

  // Only the first valid requester in round-robin order is considered; if it
  // is blocked nobody is granted, so a hazarded requester cannot be starved.
  always_comb begin
    cand_found = 1'b0;
    cand       = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!cand_found && req_valid[rr_idx(last_q, k)]) begin
        cand_found = 1'b1;
        cand       = rr_idx(last_q, k);
      end
    end
    cand_addr = '0;
    cand_data = '0;
    cand_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand == OW'(i)) begin
        cand_addr = req_address[16*i +: 16];
        cand_data = req_data[16*i +: 16];
        cand_we   = req_we[i];
      end
    end
    // Occupancy and hazard use pre-retire state: a freeing entry helps next cycle.
    tbl_full = 1'b1;
    hazard   = 1'b0;
    for (int e = 0; e < TABLE_DEPTH; e++) begin
      if (!tbl_q[e].vld) tbl_full = 1'b0;
      if (tbl_q[e].vld && tbl_q[e].addr == cand_addr) hazard = 1'b1;
    end
    // live_q keeps ready low on the first cycle out of reset.
    grant = live_q & ~reset & cand_found & ~tbl_full & ~hazard;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (cand == OW'(i));
    end
  end

  always_comb begin
    tbl_d       = tbl_q;
    last_d      = last_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    wr_done_d   = '0;
    rd_done_d   = '0;
    done_addr_d = done_addr_q;
    done_data_d = done_data_q;
    alloc_done  = 1'b0;
    wr_hit      = 1'b0;
    rd_hit      = 1'b0;
    wr_owner    = '0;
    rd_owner    = '0;

    if (grant) begin
      last_d = cand;
      if (cand_we) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cand_addr;
        wr_data_d = cand_data;
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = cand_addr;
      end
      for (int e = 0; e < TABLE_DEPTH; e++) begin
        if (!alloc_done && !tbl_q[e].vld) begin
          tbl_d[e]   = '{vld: 1'b1, addr: cand_addr, owner: cand, is_wr: cand_we};
          alloc_done = 1'b1;
        end
      end
    end

    // The allocated slot was free before this cycle, so it never collides with a retiring one.
    for (int e = 0; e < TABLE_DEPTH; e++) begin
      if (wr_ret_ack && tbl_q[e].vld && tbl_q[e].is_wr && tbl_q[e].addr == wr_ret_address) begin
        tbl_d[e].vld = 1'b0;
        wr_hit       = 1'b1;
        wr_owner     = tbl_q[e].owner;
      end
      if (rd_ret_ack && tbl_q[e].vld && !tbl_q[e].is_wr && tbl_q[e].addr == rd_ret_address) begin
        tbl_d[e].vld = 1'b0;
        rd_hit       = 1'b1;
        rd_owner     = tbl_q[e].owner;
      end
    end
    err_d = err_q | (wr_ret_ack & ~wr_hit) | (rd_ret_ack & ~rd_hit);

    // Read is applied last so it owns done_address/done_data when both hit one requester.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_hit && wr_owner == OW'(i)) begin
        wr_done_d[i]            = 1'b1;
        done_addr_d[16*i +: 16] = wr_ret_address;
        done_data_d[16*i +: 16] = '0;
      end
      if (rd_hit && rd_owner == OW'(i)) begin
        rd_done_d[i]            = 1'b1;
        done_addr_d[16*i +: 16] = rd_ret_address;
        done_data_d[16*i +: 16] = rd_ret_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < TABLE_DEPTH; e++) tbl_q[e] <= '0;
      last_q      <= OW'(NUM_REQ - 1);
      live_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      wr_done_q   <= '0;
      rd_done_q   <= '0;
      done_addr_q <= '0;
      done_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int e = 0; e < TABLE_DEPTH; e++) tbl_q[e] <= tbl_d[e];
      last_q      <= last_d;
      live_q      <= 1'b1;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      done_addr_q <= done_addr_d;
      done_data_q <= done_data_d;
      err_q       <= err_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign rd_en         = rd_en_q;
  assign wr_address    = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_address    = rd_addr_q;
  assign wr_done       = wr_done_q;
  assign rd_done       = rd_done_q;
  assign done_address  = done_addr_q;
  assign done_data     = done_data_q;
  assign err_unmatched = err_q;

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Shares the single `memory_controller` request/return port pair among `NUM_REQ` requesters. It accepts one request per cycle, chosen by round-robin, and drives it onto the controller's `wr_*`/`rd_*` inputs. It tracks every in-flight request in an outstanding table keyed by address, which is the controller's return tag. Each returned acknowledge is steered back to the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `TABLE_DEPTH`, default 8: number of outstanding-table entries; legal range 1..16.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit is high in any cycle.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_address`  in  16*NUM_REQ  request address; requester i uses bits [16i+15:16i].
- `req_data`  in  16*NUM_REQ  write data; ignored for reads.
- `wr_address`, `wr_data`  out  16 each  to the controller.
- `wr_en`  out  1  to the controller.
- `rd_address`  out  16  to the controller.
- `rd_en`  out  1  to the controller.
- `wr_ret_address`  in  16  from the controller.
- `wr_ret_ack`  in  1  from the controller.
- `rd_ret_address`, `rd_ret_data`  in  16 each  from the controller.
- `rd_ret_ack`  in  1  from the controller.
- `wr_done`  out  NUM_REQ  one-cycle pulse per requester: its write completed.
- `rd_done`  out  NUM_REQ  one-cycle pulse per requester: its read completed.
- `done_address`  out  16*NUM_REQ  per requester: address of the completed read or write.
- `done_data`  out  16*NUM_REQ  per requester: read data; 0 for a write completion.
- `err_unmatched`  out  1  sticky; set by an ack that matches no table entry.

## Operation
- Outstanding table entry fields: `valid`, `address[15:0]`, `owner`, `is_write`.
- Arbitration:
  - A round-robin pointer `last` records the most recent grant.
  - Candidates are scanned starting at `last+1` modulo NUM_REQ.
  - The first requester with `req_valid` that passes both checks below receives `req_ready`.
  - `req_ready` is combinational from the current-cycle state and inputs.
  - If the first such requester fails a check, no requester is granted that cycle. The block must not skip ahead to a lower-priority requester.
- Check 1, table full: no `valid` entry is free, so nothing is granted.
- Check 2, address hazard: any `valid` entry holds the same address, regardless of type, so the request stalls. This keeps the address tag unique and preserves per-address ordering.
- Accept (`req_valid & req_ready`):
  - Allocate the lowest-index free entry.
  - Update `last`.
  - Next cycle, drive exactly one of `wr_en`/`rd_en` high for one cycle, with `wr_address`/`wr_data` or `rd_address` registered from the accepted request.
- Write return (`wr_ret_ack`):
  - Find the valid entry with `is_write=1` and `address == wr_ret_address`, then clear it.
  - Next cycle, pulse `wr_done[owner]` with `done_address[owner]` = that address and `done_data[owner]` = 0.
- Read return (`rd_ret_ack`): same as a write return, but match `is_write=0`, pulse `rd_done[owner]`, and set `done_data[owner]` = `rd_ret_data`.
- Simultaneous write and read returns: both are processed in the same cycle. If they target the same owner, both `wr_done` and `rd_done` pulse. `done_address`/`done_data` then carry the read.
- Unmatched ack: no entry is freed, `err_unmatched` is set to 1, and no done pulse is produced.
- Same cycle as a free: allocation uses pre-free occupancy and the hazard check uses pre-free entries. A request to an address retiring this cycle therefore stalls exactly one cycle. Likewise, a full table frees capacity for the next cycle, not the current one.
- Reset:
  - Clears every table entry, sets `last` = NUM_REQ-1 so requester 0 has first priority, and clears `err_unmatched`.
  - In-flight requests are dropped. Acks arriving after reset for them are unmatched and set `err_unmatched`.

## Timing
- All outputs are 0 during reset and on the cycle after it: `req_ready`, `wr_en`, `rd_en`, all addresses/data, all done pulses, and `err_unmatched`.
- Accept in cycle N → `wr_en`/`rd_en` asserted in N+1.
- Ack in cycle M → done pulse in M+1.
- Throughput is one accepted request per cycle. Back-to-back accepts yield back-to-back `*_en` pulses.
- Each requester must hold `req_valid`, `req_we`, `req_address` and `req_data` stable until it sees `req_ready`.
- Done outputs have no backpressure. The requester must sample them on the pulse cycle.

## Test plan
- Single requester: req0 writes 0x0010 with data 0xBEEF → `wr_en` = 1 the next cycle with those values; `wr_ret_ack` for 0x0010 → `wr_done[0]` pulses one cycle later with `done_address[0]` = 0x0010.
- Round-robin: req0 and req1 both hold valid reads to distinct addresses → grants alternate 0,1,0,1, starting with req0 after reset.
- Address hazard: req0 reads 0x0040 while it is outstanding, then req1 writes 0x0040 → req1 stalls; `rd_ret_ack` for 0x0040 in cycle M → req1 is granted in M+1 at the earliest.
- Table full (TABLE_DEPTH = 2): two reads outstanding → third `req_ready` = 0; one ack → third accepted the following cycle.
- Response routing: req1 read of 0x0100 returns `rd_ret_data` = 0x1234 in the same cycle as req0's write ack → `rd_done[1]` and `wr_done[0]` pulse together, with `done_data[1]` = 0x1234.
- Errors and reset: `wr_ret_ack` for an untracked address → `err_unmatched` = 1 and stays set; assert `reset` with 3 entries outstanding → all outputs 0, then a late ack sets `err_unmatched` again.
